// File: rtl/forward_scoreboard_pkg.sv
// forward_scoreboard_pkg
//   Shared constants for the forwarding/hazard unit.
//   R_ZERO       : hard-wired zero register index (never forwarded, never tracked)
//   FWD_SEL_RF   : fwd_sel encoding meaning "take operand from the register file"
//   STG_*        : stage indices of the tracked tag pipeline
//   STALL_CNT_W  : width of the saturating stall-cycle counter
package forward_scoreboard_pkg;

    localparam int unsigned R_ZERO      = 0;
    localparam int unsigned FWD_SEL_RF  = 0;
    localparam int unsigned STG_EX      = 0;
    localparam int unsigned STG_MEM     = 1;
    localparam int unsigned STG_WB      = 2;
    localparam int unsigned STALL_CNT_W = 16;

endpackage

// File: rtl/forward_scoreboard_port_match.sv
// fwd_port_match
//   Priority encoder for one read port over the DEPTH in-flight tags.
//   Ports:
//     rd_valid     in   read port is used by the ID instruction
//     rd_addr      in   source register of this port
//     tag_valid    in   per-stage tag valid (bit s = stage s)
//     tag_rd       in   per-stage destination, stage s at [s*ADDR_W +: ADDR_W]
//     tag_load     in   per-stage "producer is a load"
//     sel          out  FWD_SEL_RF if no producer, else youngest matching stage + 1
//     is_load_hit  out  winning producer is a load whose data is not yet forwardable
module fwd_port_match
    import forward_scoreboard_pkg::*;
#(
    parameter int unsigned ADDR_W           = 4,
    parameter int unsigned DEPTH            = 3,
    parameter int unsigned SEL_W            = 2,
    parameter int unsigned LOAD_READY_STAGE = STG_MEM,
    parameter int unsigned ZERO_REG         = R_ZERO
) (
    input  logic                      rd_valid,
    input  logic [ADDR_W-1:0]         rd_addr,
    input  logic [DEPTH-1:0]          tag_valid,
    input  logic [DEPTH*ADDR_W-1:0]   tag_rd,
    input  logic [DEPTH-1:0]          tag_load,
    output logic [SEL_W-1:0]          sel,
    output logic                      is_load_hit
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    logic w_found;

    // Scan from the youngest stage; the first hit wins so an older write to
    // the same register can never shadow a newer one.
    always_comb begin
        sel         = SEL_W'(FWD_SEL_RF);
        is_load_hit = 1'b0;
        w_found     = 1'b0;
        for (int unsigned s = 0; s < DEPTH; s++) begin
            if (!w_found && rd_valid && (rd_addr != ZERO_ADDR) && tag_valid[s] &&
                (tag_rd[s*ADDR_W +: ADDR_W] == rd_addr)) begin
                w_found     = 1'b1;
                sel         = SEL_W'(s + 1);
                is_load_hit = tag_load[s] && (s < LOAD_READY_STAGE);
            end
        end
    end

endmodule

// File: rtl/forward_scoreboard.sv
// forward_scoreboard
//   Forwarding/hazard unit beside the ID/EX boundary. Tracks DEPTH stages of
//   in-flight register writes, selects the youngest producer per read port,
//   raises the load-use stall and counts stall cycles.
//   Ports:
//     clk, rst_n        clock, asynchronous active-low reset
//     hold              freeze tags and counter
//     flush             squash the ID instruction (bubble, no count)
//     issue_*           ID instruction write info
//     rd_valid/rd_addr  ID read ports, port p at [p*ADDR_W +: ADDR_W]
//     fwd_sel           port p at [p*SEL_W +: SEL_W]: 0 = regfile, k = stage k-1
//     stall             load-use stall request to IF/ID
//     stall_cnt         saturating stall-cycle counter
module forward_scoreboard
    import forward_scoreboard_pkg::*;
#(
    parameter int unsigned ADDR_W           = 4,
    parameter int unsigned NUM_RD           = 2,
    parameter int unsigned DEPTH            = 3,
    parameter int unsigned LOAD_READY_STAGE = STG_MEM,
    parameter int unsigned ZERO_REG         = R_ZERO
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   hold,
    input  logic                                   flush,
    input  logic                                   issue_valid,
    input  logic                                   issue_regwrite,
    input  logic                                   issue_is_load,
    input  logic [ADDR_W-1:0]                      issue_rd,
    input  logic [NUM_RD-1:0]                      rd_valid,
    input  logic [NUM_RD*ADDR_W-1:0]               rd_addr,
    output logic [NUM_RD*$clog2(DEPTH+1)-1:0]      fwd_sel,
    output logic                                   stall,
    output logic [STALL_CNT_W-1:0]                 stall_cnt
);

    localparam int unsigned       SEL_W     = $clog2(DEPTH + 1);
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    logic [DEPTH-1:0]           r_tag_valid;
    logic [DEPTH*ADDR_W-1:0]    r_tag_rd;
    logic [DEPTH-1:0]           r_tag_load;
    logic [STALL_CNT_W-1:0]     r_stall_cnt;

    logic [NUM_RD*SEL_W-1:0]    w_sel;
    logic [NUM_RD-1:0]          w_load_hit;
    logic                       w_issue;

    genvar p;
    generate
        for (p = 0; p < NUM_RD; p++) begin : g_port
            fwd_port_match #(
                .ADDR_W           (ADDR_W),
                .DEPTH            (DEPTH),
                .SEL_W            (SEL_W),
                .LOAD_READY_STAGE (LOAD_READY_STAGE),
                .ZERO_REG         (ZERO_REG)
            ) u_match (
                .rd_valid    (rd_valid[p]),
                .rd_addr     (rd_addr[p*ADDR_W +: ADDR_W]),
                .tag_valid   (r_tag_valid),
                .tag_rd      (r_tag_rd),
                .tag_load    (r_tag_load),
                .sel         (w_sel[p*SEL_W +: SEL_W]),
                .is_load_hit (w_load_hit[p])
            );
        end
    endgenerate

    assign stall     = |w_load_hit;
    assign fwd_sel   = stall ? {NUM_RD{SEL_W'(FWD_SEL_RF)}} : w_sel;
    assign stall_cnt = r_stall_cnt;

    // Writes to the zero register are never tracked, so they cannot forward.
    assign w_issue = issue_valid && issue_regwrite && !flush && !stall &&
                     (issue_rd != ZERO_ADDR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag_valid <= '0;
            r_tag_rd    <= '0;
            r_tag_load  <= '0;
            r_stall_cnt <= '0;
        end else if (!hold) begin
            for (int unsigned s = 1; s < DEPTH; s++) begin
                r_tag_valid[s]                 <= r_tag_valid[s-1];
                r_tag_rd[s*ADDR_W +: ADDR_W]   <= r_tag_rd[(s-1)*ADDR_W +: ADDR_W];
                r_tag_load[s]                  <= r_tag_load[s-1];
            end
            r_tag_valid[0]        <= w_issue;
            r_tag_rd[0 +: ADDR_W] <= issue_rd;
            r_tag_load[0]         <= w_issue && issue_is_load;
            if (stall && !flush && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_forward_scoreboard.sv
module tb_forward_scoreboard;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       hold = 1'b0, flush = 1'b0;
    logic       iv = 1'b0, irw = 1'b0, ild = 1'b0;
    logic [3:0] ird = '0;
    logic [1:0] rdv = '0;
    logic [7:0] rda = '0;
    logic [3:0] fwd;
    logic       stall;
    logic [15:0] cnt;

    // deep-pipeline instance used only to reach counter saturation quickly
    logic       rst2_n = 1'b0;
    logic [9:0] fwd2;
    logic       stall2;
    logic [15:0] cnt2;

    always #5 clk = ~clk;

    forward_scoreboard dut (
        .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush),
        .issue_valid(iv), .issue_regwrite(irw), .issue_is_load(ild), .issue_rd(ird),
        .rd_valid(rdv), .rd_addr(rda),
        .fwd_sel(fwd), .stall(stall), .stall_cnt(cnt)
    );

    forward_scoreboard #(.DEPTH(31), .LOAD_READY_STAGE(31)) dut2 (
        .clk(clk), .rst_n(rst2_n), .hold(1'b0), .flush(1'b0),
        .issue_valid(1'b1), .issue_regwrite(1'b1), .issue_is_load(1'b1), .issue_rd(4'd5),
        .rd_valid(2'b01), .rd_addr(8'h05),
        .fwd_sel(fwd2), .stall(stall2), .stall_cnt(cnt2)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // In-flight writes as a list indexed by age (0 = youngest).
    bit         mv[3];
    logic [3:0] mrd[3];
    bit         mld[3];
    int         mcnt;
    int         win[2];
    int         exp_sel[2];
    bit         exp_stall;
    logic [3:0] a;

    always_comb begin
        exp_stall = 1'b0;
        for (int q = 0; q < 2; q++) begin
            win[q] = -1;
            a = rda[q*4 +: 4];
            if (rdv[q] && a != 4'd0) begin
                // oldest to youngest; the last hit (youngest) overrides
                for (int s = 2; s >= 0; s--)
                    if (mv[s] && mrd[s] == a) win[q] = s;
            end
        end
        for (int q = 0; q < 2; q++)
            if (win[q] >= 0 && win[q] < 1 && mld[win[q]]) exp_stall = 1'b1;
        for (int q = 0; q < 2; q++)
            exp_sel[q] = exp_stall ? 0 : win[q] + 1;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < 3; s++) begin
                mv[s]  <= 1'b0;
                mrd[s] <= '0;
                mld[s] <= 1'b0;
            end
            mcnt <= 0;
        end else if (!hold) begin
            mv[2] <= mv[1];  mrd[2] <= mrd[1];  mld[2] <= mld[1];
            mv[1] <= mv[0];  mrd[1] <= mrd[0];  mld[1] <= mld[0];
            mv[0]  <= iv && irw && !flush && !exp_stall && (ird != 4'd0);
            mrd[0] <= ird;
            mld[0] <= ild;
            if (exp_stall && !flush && mcnt < 65535) mcnt <= mcnt + 1;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_fwd0",  {30'd0, fwd[1:0]}, exp_sel[0]);
            chk("cyc_fwd1",  {30'd0, fwd[3:2]}, exp_sel[1]);
            chk("cyc_stall", {31'd0, stall}, {31'd0, exp_stall});
            chk("cyc_cnt",   {16'd0, cnt}, mcnt);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        iv = 0; irw = 0; ild = 0; ird = 0; rdv = 0; rda = 0; hold = 0; flush = 0;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        repeat (2) @(posedge clk);
        #2;
        chk("rst_fwd", {28'd0, fwd}, 0);
        chk("rst_stall", {31'd0, stall}, 0);
        chk("rst_cnt", {16'd0, cnt}, 0);
        rst_n = 1;
        cmp_en = 1;

        // ALU producer r3 walks EX -> MEM -> WB -> retired
        iv = 1; irw = 1; ird = 4'd3;
        tick();
        idle(); rdv = 2'b01; rda = 8'h03;
        #4 chk("alu_ex", {30'd0, fwd[1:0]}, 1);
        tick(); #4 chk("alu_mem", {30'd0, fwd[1:0]}, 2);
        tick(); #4 chk("alu_wb", {30'd0, fwd[1:0]}, 3);
        tick(); #4 chk("alu_ret", {30'd0, fwd[1:0]}, 0);

        // load-use on port1: one stall cycle, then forward from MEM
        idle(); iv = 1; irw = 1; ild = 1; ird = 4'd5;
        tick();
        idle(); rdv = 2'b10; rda = 8'h50;
        #4 chk("lu_stall", {31'd0, stall}, 1);
        chk("lu_fwd0", {28'd0, fwd}, 0);
        tick(); #4 chk("lu_fwd1", {30'd0, fwd[3:2]}, 2);
        chk("lu_nostall", {31'd0, stall}, 0);
        chk("lu_cnt", {16'd0, cnt}, 1);

        // WAW: youngest r2 wins; r0 never tracked
        idle(); iv = 1; irw = 1; ird = 4'd2;
        tick(); tick();
        ird = 4'd0; rdv = 2'b01; rda = 8'h02;
        #4 chk("waw_young", {30'd0, fwd[1:0]}, 1);
        tick();
        idle(); rdv = 2'b11; rda = 8'h02;
        #4 chk("waw_next", {30'd0, fwd[1:0]}, 2);
        chk("zero_reg", {30'd0, fwd[3:2]}, 0);

        // load-use held for 3 cycles
        idle(); iv = 1; irw = 1; ild = 1; ird = 4'd4;
        tick();
        idle(); rdv = 2'b01; rda = 8'h04; hold = 1;
        #4 chk("hold_stall", {31'd0, stall}, 1);
        for (int i = 0; i < 3; i++) begin
            tick(); #4 chk("hold_stall_k", {31'd0, stall}, 1);
            chk("hold_cnt", {16'd0, cnt}, 1);
        end
        hold = 0;
        #1 chk("hold_rel_stall", {31'd0, stall}, 1);
        tick(); #4 chk("hold_fwd", {30'd0, fwd[1:0]}, 2);
        chk("hold_cnt2", {16'd0, cnt}, 2);

        // flush during stall: bubble, no count
        idle(); iv = 1; irw = 1; ild = 1; ird = 4'd6;
        tick();
        idle(); rdv = 2'b01; rda = 8'h06; flush = 1;
        #4 chk("fl_stall", {31'd0, stall}, 1);
        tick(); flush = 0;
        #4 chk("fl_fwd", {30'd0, fwd[1:0]}, 2);
        chk("fl_cnt", {16'd0, cnt}, 2);

        // reset mid-stream with three valid tags
        idle(); iv = 1; irw = 1; ird = 4'd7;
        tick(); ird = 4'd8;
        tick(); ird = 4'd9;
        tick();
        idle(); rdv = 2'b01; rda = 8'h07;
        #4 chk("pre_rst_fwd", {30'd0, fwd[1:0]}, 3);
        rst_n = 0;
        #1 chk("mid_rst_fwd", {28'd0, fwd}, 0);
        chk("mid_rst_stall", {31'd0, stall}, 0);
        chk("mid_rst_cnt", {16'd0, cnt}, 0);
        tick();
        rst_n = 1;
        #4 chk("post_rst_fwd", {30'd0, fwd[1:0]}, 0);
        idle();

        // saturation: 31 stalls per 32 cycles on the deep instance
        tick();
        rst2_n = 1;
        tick(); #4 chk("sat_first_stall", {31'd0, stall2}, 1);
        repeat (31) tick();
        chk("sat_cnt31", {16'd0, cnt2}, 31);
        repeat (68000 - 32) tick();
        chk("sat_ffff", {16'd0, cnt2}, 32'h0000FFFF);
        repeat (40) tick();
        chk("sat_hold", {16'd0, cnt2}, 32'h0000FFFF);

        cmp_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
